// File: rtl/or1200_vlx_rd.sv
// JPEG entropy bit-stream reader: byte fetch, 0xFF/0x00 unstuffing, marker stop, get-n-bits.
// Optional VLX_RD_PEEK_EN adds peek_i for non-consuming reads.
module or1200_vlx_rd #(
    parameter logic [31:0] RST_ADDR   = 32'h0000_0000,
    parameter int          REFILL_LVL = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        get_bit_op_i,
    input  logic [4:0]  num_bits_to_read_i,
    output logic [31:0] dat_o,
    output logic        stall_cpu_o,
    input  logic        spr_cs,
    input  logic        spr_write,
    input  logic [1:0]  spr_addr,
    input  logic [31:0] spr_dat_i,
    output logic [31:0] spr_dat_o,
    output logic        ld_req_o,
    output logic [31:0] ld_addr_o,
    input  logic [31:0] ld_dat_i,
    input  logic        ack_i
`ifdef VLX_RD_PEEK_EN
    ,
    input  logic        peek_i
`endif
);

    typedef enum logic {F_IDLE, F_REQ} fstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DONE} rstate_t;

    localparam logic [5:0] LVL = 6'(REFILL_LVL);

    fstate_t     fst_q, fst_n;
    rstate_t     rst_q, rst_n;
    logic [31:0] bits_q, ptr_q, addr_q;
    logic [5:0]  fill_q;
    logic [7:0]  mbyte_q;
    logic        prev_ff_q, marker_q, underrun_q, drop_q;

    logic        ptr_wr, ack_ok, take, append, new_marker, pk;
    logic [7:0]  byte_in;
    logic [4:0]  ne, pad_sh;
    logic [47:0] wide;
    logic [15:0] top, pad;
    logic        have, flush_rd, set_ur;
    logic [5:0]  cons, fill_k, fill_n;
    logic [31:0] kept, bits_n, dat_n;
    logic        unused_bits;

`ifdef VLX_RD_PEEK_EN
    assign pk = peek_i;
`else
    assign pk = 1'b0;
`endif

    assign unused_bits = ^{ld_dat_i[31:8], spr_addr[0]};

    assign ptr_wr     = spr_cs & spr_write & spr_addr[1];
    assign byte_in    = ld_dat_i[7:0];
    assign ack_ok     = (fst_q == F_REQ) & ack_i;
    // A byte requested before a pointer write belongs to the old stream.
    assign take       = ack_ok & ~drop_q & ~ptr_wr;
    assign append     = take & ~prev_ff_q;
    assign new_marker = take & prev_ff_q & (byte_in != 8'h00);

    assign ld_req_o  = (fst_q == F_REQ);
    assign ld_addr_o = addr_q;

    assign stall_cpu_o = rst_i & (((rst_q == R_IDLE) & get_bit_op_i)
                                  | (rst_q == R_WAIT));

    assign spr_dat_o = !spr_cs      ? 32'h0 :
                       spr_addr[1]  ? ptr_q :
                       {10'b0, fill_q, mbyte_q, 6'b0, underrun_q, marker_q};

    always_comb begin
        fst_n = fst_q;
        unique case (fst_q)
            F_IDLE: if (fill_q <= LVL && !marker_q && !ptr_wr) fst_n = F_REQ;
            F_REQ:  if (ack_i) fst_n = F_IDLE;
        endcase
    end

    assign ne     = (num_bits_to_read_i > 5'd16) ? 5'd16 : num_bits_to_read_i;
    assign wide   = {16'b0, bits_q} << ne;
    assign top    = wide[47:32];
    assign have   = ({1'b0, ne} <= fill_q);
    assign pad_sh = ne - fill_q[4:0];
    assign pad    = ~(16'hFFFF << pad_sh);

    always_comb begin
        rst_n    = rst_q;
        dat_n    = dat_o;
        cons     = 6'd0;
        flush_rd = 1'b0;
        set_ur   = 1'b0;
        unique case (rst_q)
            R_IDLE, R_WAIT: begin
                if (rst_q == R_WAIT || get_bit_op_i) begin
                    if (have) begin
                        dat_n = {16'b0, top};
                        cons  = pk ? 6'd0 : {1'b0, ne};
                        rst_n = R_DONE;
                    end else if (marker_q) begin
                        // Stream ended at a marker: hand back what is left, 1-padded.
                        dat_n    = {16'b0, top | pad};
                        flush_rd = ~pk;
                        set_ur   = ~pk;
                        rst_n    = R_DONE;
                    end else begin
                        rst_n = R_WAIT;
                    end
                end
            end
            R_DONE:  rst_n = R_IDLE;
            default: rst_n = R_IDLE;
        endcase
    end

    assign kept   = flush_rd ? 32'h0 : (bits_q << cons);
    assign fill_k = flush_rd ? 6'd0 : (fill_q - cons);
    assign bits_n = append ? (kept | ({byte_in, 24'b0} >> fill_k)) : kept;
    assign fill_n = append ? (fill_k + 6'd8) : fill_k;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fst_q      <= F_IDLE;
            rst_q      <= R_IDLE;
            dat_o      <= 32'h0;
            bits_q     <= 32'h0;
            fill_q     <= 6'd0;
            ptr_q      <= RST_ADDR;
            addr_q     <= 32'h0;
            mbyte_q    <= 8'h0;
            prev_ff_q  <= 1'b0;
            marker_q   <= 1'b0;
            underrun_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            fst_q <= fst_n;
            rst_q <= rst_n;
            dat_o <= dat_n;
            if (fst_q == F_IDLE && fst_n == F_REQ) addr_q <= ptr_q;
            if (ptr_wr) begin
                ptr_q      <= spr_dat_i;
                bits_q     <= 32'h0;
                fill_q     <= 6'd0;
                prev_ff_q  <= 1'b0;
                marker_q   <= 1'b0;
                underrun_q <= 1'b0;
                drop_q     <= (fst_q == F_REQ) & ~ack_i;
            end else begin
                bits_q <= bits_n;
                fill_q <= fill_n;
                if (take) begin
                    ptr_q     <= ptr_q + 32'd1;
                    prev_ff_q <= ~prev_ff_q & (byte_in == 8'hFF);
                end
                if (new_marker) begin
                    marker_q <= 1'b1;
                    mbyte_q  <= byte_in;
                end
                if (set_ur) underrun_q <= 1'b1;
                if (ack_ok) drop_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_or1200_vlx_rd.sv
// Bench for or1200_vlx_rd: vector tables, corner sequences and a random
// stream checked against a bit-queue model.
module tb_or1200_vlx_rd;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        op;
    logic [4:0]  nbits;
    logic [31:0] dat_o;
    logic        stall_cpu_o;
    logic        spr_cs, spr_write;
    logic [1:0]  spr_addr;
    logic [31:0] spr_dat_i, spr_dat_o;
    logic        ld_req_o;
    logic [31:0] ld_addr_o;
    logic [31:0] ld_dat_i;
    logic        ack_i;
    logic        peek;

    always #5 clk = ~clk;

    or1200_vlx_rd dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .get_bit_op_i(op),
        .num_bits_to_read_i(nbits),
        .dat_o(dat_o),
        .stall_cpu_o(stall_cpu_o),
        .spr_cs(spr_cs),
        .spr_write(spr_write),
        .spr_addr(spr_addr),
        .spr_dat_i(spr_dat_i),
        .spr_dat_o(spr_dat_o),
        .ld_req_o(ld_req_o),
        .ld_addr_o(ld_addr_o),
        .ld_dat_i(ld_dat_i),
        .ack_i(ack_i)
`ifdef VLX_RD_PEEK_EN
        ,
        .peek_i(peek)
`endif
    );

    int pass_cnt = 0;
    int total = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    endtask

    // Byte memory; unmapped addresses answer only requests made stale by a pointer write.
    logic [7:0] mem [logic [31:0]];
    int ack_dly = 0;
    int stale_epoch = 0;
    int served_epoch = 0;

    initial begin : memory
        int mcnt;
        mcnt = 0;
        ack_i = 1'b0;
        ld_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            ack_i = 1'b0;
            if (ld_req_o) begin
                if (mcnt >= ack_dly &&
                    (mem.exists(ld_addr_o) || stale_epoch != served_epoch)) begin
                    ack_i = 1'b1;
                    ld_dat_i = mem.exists(ld_addr_o) ?
                               {24'hA5A5A5, mem[ld_addr_o]} : 32'hFFFF_FF00;
                    served_epoch = stale_epoch;
                    mcnt = 0;
                end else begin
                    mcnt++;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    task automatic spr_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        if (a[1] && ld_req_o) stale_epoch++;
        spr_cs = 1'b1;
        spr_write = 1'b1;
        spr_addr = a;
        spr_dat_i = d;
        @(negedge clk);
        spr_cs = 1'b0;
        spr_write = 1'b0;
    endtask

    task automatic spr_rd(input logic [1:0] a, output logic [31:0] d);
        spr_cs = 1'b1;
        spr_write = 1'b0;
        spr_addr = a;
        #1;
        d = spr_dat_o;
        spr_cs = 1'b0;
    endtask

    task automatic do_get(input logic [4:0] n, input logic pk,
                          output logic [31:0] d, output int lat);
        @(negedge clk);
        op = 1'b1;
        nbits = n;
        peek = pk;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (stall_cpu_o && lat < 400);
        if (stall_cpu_o) begin
            total++;
            $display("FAIL get_timeout: stall still 1 after %0d cycles, want 0", lat);
        end
        d = dat_o;
        op = 1'b0;
        peek = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  n;
        logic        pk;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[7];

    task automatic run_vecs(input int lo, input int hi, input string nm);
        logic [31:0] d;
        int lat;
        for (int i = lo; i <= hi; i++) begin
            do_get(tv[i].n, tv[i].pk, d, lat);
            chk($sformatf("%s[%0d]", nm, i), d, tv[i].exp);
        end
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] d;
        int lat, seen, stop, cnt;
        logic saw8;
        logic [7:0] lb [48];
        bit q[$];
        logic [31:0] a;
        logic [4:0] n;
        int ne;
        logic [31:0] exp;

        tv[0] = '{5'd4,  1'b0, 32'h00A};
        tv[1] = '{5'd8,  1'b0, 32'h05F};
        tv[2] = '{5'd12, 1'b0, 32'hF3C};
        tv[3] = '{5'd8,  1'b0, 32'h012};
        tv[4] = '{5'd8,  1'b0, 32'h0FF};
        tv[5] = '{5'd12, 1'b0, 32'h12A};
        tv[6] = '{5'd16, 1'b0, 32'h0FFF};

        rst_i = 1'b0;
        op = 1'b0;
        nbits = 5'd0;
        peek = 1'b0;
        spr_cs = 1'b0;
        spr_write = 1'b0;
        spr_addr = 2'd0;
        spr_dat_i = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_stall", {31'b0, stall_cpu_o}, 32'h0);
        chk("rst_ldreq", {31'b0, ld_req_o}, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        spr_rd(2'd0, d);
        chk("rst_status", d, 32'h0);
        spr_rd(2'd2, d);
        chk("rst_ptr", d, 32'h0);

        @(negedge clk);
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("fetch_start_req", {31'b0, ld_req_o}, 32'h1);
        chk("fetch_start_addr", ld_addr_o, 32'h0);

        // Reset while an op waits on an empty stream.
        op = 1'b1;
        nbits = 5'd8;
        repeat (3) @(negedge clk);
        chk("wait_stall", {31'b0, stall_cpu_o}, 32'h1);
        #2 rst_i = 1'b0;
        #1 chk("async_stall_drop", {31'b0, stall_cpu_o}, 32'h0);
        chk("async_ldreq_drop", {31'b0, ld_req_o}, 32'h0);
        @(negedge clk);
        op = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        repeat (2) @(negedge clk);

        mem[32'h1000] = 8'hA5;
        mem[32'h1001] = 8'hFF;
        mem[32'h1002] = 8'h00;
        mem[32'h1003] = 8'h3C;
        spr_wr(2'd2, 32'h1000);
        run_vecs(0, 2, "stuff");
        repeat (10) @(negedge clk);
        spr_rd(2'd2, d);
        chk("stuff_ptr", d, 32'h1004);
        spr_rd(2'd0, d);
        chk("stuff_status", d, 32'h0);

        mem[32'h1100] = 8'h01;
        mem[32'h1101] = 8'h82;
        spr_wr(2'd2, 32'h1100);
        repeat (12) @(negedge clk);
        do_get(5'd0, 1'b0, d, lat);
        chk("get0_dat", d, 32'h0);
        chk("get0_lat", lat, 1);
        spr_rd(2'd0, d);
        chk("get0_fill", d, 32'h0010_0000);
        do_get(5'd20, 1'b0, d, lat);
        chk("get20_dat", d, 32'h0182);
        chk("get20_lat", lat, 1);
        spr_rd(2'd0, d);
        chk("get20_fill", d, 32'h0);

        // get 16 right after a pointer write with slow memory.
        mem[32'h1200] = 8'hC3;
        mem[32'h1201] = 8'h5E;
        ack_dly = 3;
        spr_wr(2'd2, 32'h1200);
        op = 1'b1;
        nbits = 5'd16;
        seen = -1;
        stop = -1;
        saw8 = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            spr_rd(2'd0, d);
            if (!stall_cpu_o) begin
                stop = c;
                break;
            end
            if (d[21:16] == 6'd8) saw8 = 1'b1;
            if (d[21:16] >= 6'd16 && seen < 0) seen = c;
        end
        chk("slow_dat", dat_o, 32'hC35E);
        op = 1'b0;
        chk("slow_held_at8", {31'b0, saw8}, 32'h1);
        chk("slow_seen16", {31'b0, seen > 0}, 32'h1);
        chk("slow_one_cycle", stop, seen + 1);
        ack_dly = 0;

        mem[32'h1300] = 8'h12;
        mem[32'h1301] = 8'hFF;
        mem[32'h1302] = 8'hD9;
        spr_wr(2'd2, 32'h1300);
        run_vecs(3, 4, "mark");
        repeat (10) @(negedge clk);
        spr_rd(2'd0, d);
        chk("mark_status", d, 32'h0000_D901);
        spr_rd(2'd2, d);
        chk("mark_ptr", d, 32'h1303);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ld_req_o) cnt++;
        end
        chk("mark_no_fetch", cnt, 0);
        do_get(5'd4, 1'b0, d, lat);
        chk("underrun_empty", d, 32'hF);
        spr_rd(2'd0, d);
        chk("underrun_status", d, 32'h0000_D903);

        mem[32'h1400] = 8'h12;
        mem[32'h1401] = 8'hA0;
        mem[32'h1402] = 8'hFF;
        mem[32'h1403] = 8'hC0;
        spr_wr(2'd2, 32'h1400);
        run_vecs(5, 6, "pad");
        spr_rd(2'd0, d);
        chk("pad_status", d, 32'h0000_C003);

        // Pointer rewritten while a fetch is outstanding.
        mem[32'h1500] = 8'h77;
        mem[32'h1600] = 8'h5A;
        mem[32'h1601] = 8'h3B;
        ack_dly = 4;
        spr_wr(2'd2, 32'h1500);
        repeat (2) @(negedge clk);
        chk("inflight_req", {31'b0, ld_req_o}, 32'h1);
        chk("inflight_addr", ld_addr_o, 32'h1500);
        spr_wr(2'd2, 32'h1600);
        do_get(5'd16, 1'b0, d, lat);
        chk("stale_dat", d, 32'h5A3B);
        spr_rd(2'd2, d);
        chk("stale_ptr", d, 32'h1602);
        ack_dly = 0;

`ifdef VLX_RD_PEEK_EN
        mem[32'h1700] = 8'hA5;
        spr_wr(2'd2, 32'h1700);
        repeat (10) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            do_get(5'd8, 1'b1, d, lat);
            chk($sformatf("peek%0d_dat", k), d, 32'hA5);
            spr_rd(2'd0, d);
            chk($sformatf("peek%0d_fill", k), d, 32'h0008_0000);
        end
        do_get(5'd8, 1'b0, d, lat);
        chk("peek_get_dat", d, 32'hA5);
        spr_rd(2'd0, d);
        chk("peek_get_fill", d, 32'h0);
`endif

        // Random stream: model is the unstuffed bit sequence as a queue.
        a = 32'h8000;
        for (int i = 0; i < 48; i++) begin
            lb[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            mem[a] = lb[i];
            a++;
            if (lb[i] == 8'hFF) begin
                mem[a] = 8'h00;
                a++;
            end
            for (int b = 7; b >= 0; b--) q.push_back(lb[i][b]);
        end
        spr_wr(2'd2, 32'h8000);
        while (q.size() >= 16) begin
            n = 5'($urandom_range(0, 20));
            ack_dly = $urandom_range(0, 3);
            ne = (n > 5'd16) ? 16 : int'(n);
            exp = 32'h0;
            for (int b = 0; b < ne; b++) exp = {exp[30:0], q.pop_front()};
            do_get(n, 1'b0, d, lat);
            chk($sformatf("rand_n%0d", n), d, exp);
        end
        ack_dly = 0;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
